// File: rtl/cacheline_adapter_pkg.sv
// Shared types and widths for the cache line to banked-memory burst adapter.
package rv32i_types;

  localparam int LINE_W = 256;
  localparam int BEAT_W = 64;
  localparam int BEATS  = 4;
  localparam int CNT_W  = 2;

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR      = 3'd1,
    RD_REQ  = 3'd2,
    RD_WAIT = 3'd3,
    RESP    = 3'd4,
    HOLD    = 3'd5
  } cla_state_t;

endpackage

// File: rtl/cacheline_adapter_line_beat_buffer.sv
// Four-beat read line register with beat-indexed write and a write-through view
// of the whole line, so the final beat is visible in the same cycle it arrives.
module line_beat_buffer
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 we_i,
  input  logic [CNT_W-1:0]     idx_i,
  input  logic [BEAT_W-1:0]    wdata_i,
  output logic [LINE_W-1:0]    line_o
);

  logic [BEAT_W-1:0] beat_q [BEATS];

  always_ff @(posedge clk) begin
    if (rst) begin
      for (int i = 0; i < BEATS; i++) begin
        beat_q[i] <= '0;
      end
    end else if (we_i) begin
      beat_q[idx_i] <= wdata_i;
    end
  end

  // Read mux: a beat being written this cycle bypasses its stored copy.
  always_comb begin
    line_o = '0;
    for (int i = 0; i < BEATS; i++) begin
      if (we_i && (idx_i == CNT_W'(i))) begin
        line_o[i*BEAT_W +: BEAT_W] = wdata_i;
      end else begin
        line_o[i*BEAT_W +: BEAT_W] = beat_q[i];
      end
    end
  end

endmodule

// File: rtl/cacheline_adapter.sv
// Converts 256-bit line read/write requests into four 64-bit bmem bursts.
// Optional protocol checking on err is enabled by CACHELINE_ADAPTER_CHECK_EN.
module cacheline_adapter
  import rv32i_types::*;
(
  input  logic                 clk,
  input  logic                 rst,
  input  logic [31:0]          dfp_addr,
  input  logic                 dfp_read,
  input  logic                 dfp_write,
  input  logic [LINE_W-1:0]    dfp_wdata,
  output logic [LINE_W-1:0]    dfp_rdata,
  output logic                 dfp_resp,
  output logic [31:0]          bmem_addr,
  output logic                 bmem_read,
  output logic                 bmem_write,
  output logic [BEAT_W-1:0]    bmem_wdata,
  input  logic                 bmem_ready,
  input  logic [31:0]          bmem_raddr,
  input  logic [BEAT_W-1:0]    bmem_rdata,
  input  logic                 bmem_rvalid,
  output logic                 err
);

  cla_state_t         state_q, state_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic [31:0]        addr_q, addr_d;
  logic [LINE_W-1:0]  wdata_q, wdata_d;
  logic [LINE_W-1:0]  rdata_q, rdata_d;
  logic               beatWe;
  logic [LINE_W-1:0]  lineView;
  logic               unused_bits;

  line_beat_buffer u_line_buf (
    .clk     (clk),
    .rst     (rst),
    .we_i    (beatWe),
    .idx_i   (cnt_q),
    .wdata_i (bmem_rdata),
    .line_o  (lineView)
  );

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    addr_d  = addr_q;
    wdata_d = wdata_q;
    rdata_d = rdata_q;
    beatWe  = 1'b0;
    unique case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (dfp_write) begin
          addr_d  = {dfp_addr[31:5], 5'b0};
          wdata_d = dfp_wdata;
          state_d = WR;
        end else if (dfp_read) begin
          addr_d  = {dfp_addr[31:5], 5'b0};
          state_d = RD_REQ;
        end
      end
      WR: begin
        if (bmem_ready) begin
          cnt_d = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) state_d = RESP;
        end
      end
      RD_REQ: begin
        if (bmem_ready) begin
          cnt_d   = '0;
          state_d = RD_WAIT;
        end
      end
      RD_WAIT: begin
        if (bmem_rvalid) begin
          beatWe = 1'b1;
          cnt_d  = cnt_q + 1'b1;
          if (cnt_q == CNT_W'(BEATS - 1)) begin
            rdata_d = lineView;
            state_d = RESP;
          end
        end
      end
      RESP:    state_d = HOLD;
      HOLD:    state_d = IDLE;
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      addr_q  <= addr_d;
      wdata_q <= wdata_d;
      rdata_q <= rdata_d;
    end
  end

  assign dfp_resp   = (state_q == RESP);
  assign dfp_rdata  = rdata_q;
  assign bmem_addr  = addr_q;
  assign bmem_read  = (state_q == RD_REQ);
  assign bmem_write = (state_q == WR);
  assign bmem_wdata = (state_q == WR) ? wdata_q[{cnt_q, 6'b0} +: BEAT_W] : '0;

`ifdef CACHELINE_ADAPTER_CHECK_EN
  logic err_q, err_d;
  logic protoViolation;

  assign protoViolation = bmem_rvalid &&
                          ((state_q != RD_WAIT) || (bmem_raddr != addr_q));

  always_comb begin
    err_d = err_q;
    if (protoViolation) err_d = 1'b1;
  end

  always_ff @(posedge clk) begin
    if (rst) err_q <= 1'b0;
    else     err_q <= err_d;
  end

`ifndef SYNTHESIS
  always_ff @(posedge clk) begin
    if (!rst && protoViolation)
      $error("cacheline_adapter: unexpected rvalid or raddr %h vs %h", bmem_raddr, addr_q);
  end
`endif

  assign err         = err_q;
  assign unused_bits = ^dfp_addr[4:0];
`else
  assign err         = 1'b0;
  assign unused_bits = ^{dfp_addr[4:0], bmem_raddr};
`endif

endmodule

// File: tb/tb_cacheline_adapter.sv
// Directed bench for cacheline_adapter: write/read bursts, stalls, held
// requests, simultaneous requests and mid-burst reset.
module tb_cacheline_adapter;

  logic         clk;
  logic         rst;
  logic [31:0]  dfp_addr;
  logic         dfp_read;
  logic         dfp_write;
  logic [255:0] dfp_wdata;
  logic [255:0] dfp_rdata;
  logic         dfp_resp;
  logic [31:0]  bmem_addr;
  logic         bmem_read;
  logic         bmem_write;
  logic [63:0]  bmem_wdata;
  logic         bmem_ready;
  logic [31:0]  bmem_raddr;
  logic [63:0]  bmem_rdata;
  logic         bmem_rvalid;
  logic         err;

  int assertCount = 0;
  int failCount   = 0;
  int respCount   = 0;

  cacheline_adapter dut (
    .clk         (clk),
    .rst         (rst),
    .dfp_addr    (dfp_addr),
    .dfp_read    (dfp_read),
    .dfp_write   (dfp_write),
    .dfp_wdata   (dfp_wdata),
    .dfp_rdata   (dfp_rdata),
    .dfp_resp    (dfp_resp),
    .bmem_addr   (bmem_addr),
    .bmem_read   (bmem_read),
    .bmem_write  (bmem_write),
    .bmem_wdata  (bmem_wdata),
    .bmem_ready  (bmem_ready),
    .bmem_raddr  (bmem_raddr),
    .bmem_rdata  (bmem_rdata),
    .bmem_rvalid (bmem_rvalid),
    .err         (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  always @(negedge clk) begin
    if (dfp_resp === 1'b1) respCount++;
  end

  task automatic checkOutput(input string tag, input logic [255:0] observed,
                             input logic [255:0] expected);
    assertCount++;
    if (observed !== expected) begin
      failCount++;
      $display("[TB] FAIL %s: got %h expected %h", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic wr, input logic rd, input logic [31:0] addr,
                               input logic [255:0] wdata);
    dfp_write = wr;
    dfp_read  = rd;
    dfp_addr  = addr;
    dfp_wdata = wdata;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic feedBeat(input logic valid, input logic [31:0] raddr, input logic [63:0] data);
    bmem_rvalid = valid;
    bmem_raddr  = raddr;
    bmem_rdata  = data;
  endtask

  logic [63:0]  beatsA [4];
  logic [63:0]  beatsC [4];
  logic [63:0]  beatsB [4];
  logic [63:0]  beatsE [4];
  logic [255:0] lineB, lineE;
  logic [4:0]   gapPat;
  int           k, lastAccept, respAt, respBefore;
  logic         readyToggle;

  initial begin
    beatsA = '{64'hA0, 64'hA1, 64'hA2, 64'hA3};
    beatsC = '{64'hC0C0_0000_0000_00C0, 64'hC1, 64'hC2, 64'hC3C3_0000_0000_00C3};
    beatsB = '{64'hB000_0000_0000_00B0, 64'hB1, 64'hB2, 64'hB333_0000_0000_00B3};
    beatsE = '{64'hE0, 64'hE1, 64'hE2, 64'hE3};
    lineB  = {beatsB[3], beatsB[2], beatsB[1], beatsB[0]};
    lineE  = {beatsE[3], beatsE[2], beatsE[1], beatsE[0]};

    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    bmem_ready = 1'b1;
    feedBeat(1'b0, 32'h0, 64'h0);
    tick();
    tick();
    rst = 1'b0;
    checkOutput("rst_resp", {255'b0, dfp_resp}, 256'h0);
    checkOutput("rst_rdata", dfp_rdata, 256'h0);
    checkOutput("rst_bmem_rd_wr", {254'b0, bmem_read, bmem_write}, 256'h0);
    checkOutput("rst_bmem_addr", {224'b0, bmem_addr}, 256'h0);
    checkOutput("rst_bmem_wdata", {192'b0, bmem_wdata}, 256'h0);
    checkOutput("rst_err", {255'b0, err}, 256'h0);

    // Write with ready always high: beats in cycles 1-4, resp in cycle 5.
    applyStimulus(1'b1, 1'b0, 32'h0000_1234,
                  {beatsA[3], beatsA[2], beatsA[1], beatsA[0]});
    tick();
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("wr1_valid%0d", i), {255'b0, bmem_write}, 256'h1);
      checkOutput($sformatf("wr1_addr%0d", i), {224'b0, bmem_addr}, 256'h1220);
      checkOutput($sformatf("wr1_data%0d", i), {192'b0, bmem_wdata}, {192'b0, beatsA[i]});
      checkOutput($sformatf("wr1_noresp%0d", i), {255'b0, dfp_resp}, 256'h0);
      tick();
    end
    checkOutput("wr1_resp", {255'b0, dfp_resp}, 256'h1);
    checkOutput("wr1_write_off", {255'b0, bmem_write}, 256'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("wr1_hold_noresp", {255'b0, dfp_resp}, 256'h0);
    tick();
    checkOutput("wr1_idle_quiet", {254'b0, bmem_read, bmem_write}, 256'h0);

    // Write with ready toggling 1,0,1,0...
    respBefore = respCount;
    k = 0;
    lastAccept = -10;
    respAt = -1;
    readyToggle = 1'b1;
    applyStimulus(1'b1, 1'b0, 32'h2000_0047,
                  {beatsC[3], beatsC[2], beatsC[1], beatsC[0]});
    tick();
    for (int c = 1; c < 20 && respAt < 0; c++) begin
      bmem_ready = readyToggle;
      if (dfp_resp === 1'b1) begin
        respAt = c;
      end else if (bmem_write === 1'b1) begin
        checkOutput($sformatf("wr2_addr_c%0d", c), {224'b0, bmem_addr}, 256'h2000_0040);
        if (k < 4)
          checkOutput($sformatf("wr2_data_c%0d", c), {192'b0, bmem_wdata}, {192'b0, beatsC[k]});
        if (bmem_ready) begin
          k++;
          lastAccept = c;
        end
      end
      readyToggle = ~readyToggle;
      tick();
    end
    bmem_ready = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    checkOutput("wr2_beats", 256'(k), 256'd4);
    checkOutput("wr2_resp_timing", 256'(respAt), 256'(lastAccept + 1));
    tick();
    tick();
    checkOutput("wr2_one_resp", 256'(respCount - respBefore), 256'd1);

    // Read, ready low 3 cycles, beats with one gap; read held through HOLD.
    respBefore = respCount;
    bmem_ready = 1'b0;
    applyStimulus(1'b0, 1'b1, 32'h0000_3468, '0);
    tick();
    for (int c = 1; c <= 4; c++) begin
      checkOutput($sformatf("rd1_cmd_c%0d", c), {255'b0, bmem_read}, 256'h1);
      checkOutput($sformatf("rd1_addr_c%0d", c), {224'b0, bmem_addr}, 256'h3460);
      bmem_ready = (c == 4);
      tick();
    end
    checkOutput("rd1_cmd_off", {255'b0, bmem_read}, 256'h0);
    gapPat = 5'b11011;
    k = 0;
    for (int c = 0; c < 5; c++) begin
      if (gapPat[4 - c]) begin
        feedBeat(1'b1, 32'h0000_3460, beatsB[k]);
        k++;
      end else begin
        feedBeat(1'b0, 32'h0000_3460, 64'hDEAD);
      end
      tick();
    end
    feedBeat(1'b0, 32'h0, 64'h0);
    checkOutput("rd1_resp", {255'b0, dfp_resp}, 256'h1);
    checkOutput("rd1_rdata", dfp_rdata, lineB);
    tick();
    checkOutput("rd1_hold_noresp", {255'b0, dfp_resp}, 256'h0);
    checkOutput("rd1_hold_nocmd", {255'b0, bmem_read}, 256'h0);
    tick();
    checkOutput("rd1_idle_nocmd", {255'b0, bmem_read}, 256'h0);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    checkOutput("rd1_no_second_burst", {255'b0, bmem_read}, 256'h0);
    checkOutput("rd1_rdata_kept", dfp_rdata, lineB);
    checkOutput("rd1_one_resp", 256'(respCount - respBefore), 256'd1);

    // Write and read together: write first, read picked up after HOLD.
    bmem_ready = 1'b1;
    respBefore = respCount;
    applyStimulus(1'b1, 1'b1, 32'h0000_5010, {4{64'hD0D0}});
    tick();
    checkOutput("both_write_first", {254'b0, bmem_read, bmem_write}, 256'h1);
    for (int c = 0; c < 4; c++) tick();
    checkOutput("both_wr_resp", {255'b0, dfp_resp}, 256'h1);
    checkOutput("both_rdata_after_write", dfp_rdata, lineB);
    dfp_write = 1'b0;
    tick();
    checkOutput("both_hold_nocmd", {255'b0, bmem_read}, 256'h0);
    tick();
    checkOutput("both_idle_nocmd", {255'b0, bmem_read}, 256'h0);
    tick();
    checkOutput("both_read_cmd", {255'b0, bmem_read}, 256'h1);
    checkOutput("both_read_addr", {224'b0, bmem_addr}, 256'h5000);
    tick();
    for (int c = 0; c < 4; c++) begin
      feedBeat(1'b1, 32'h0000_5000, beatsE[c]);
      tick();
    end
    feedBeat(1'b0, 32'h0, 64'h0);
    checkOutput("both_rd_resp", {255'b0, dfp_resp}, 256'h1);
    checkOutput("both_rd_rdata", dfp_rdata, lineE);
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    tick();
    checkOutput("both_two_resps", 256'(respCount - respBefore), 256'd2);

    // Reset during beat 2 of a read abandons it.
    respBefore = respCount;
    applyStimulus(1'b0, 1'b1, 32'h0000_7000, '0);
    tick();
    tick();
    feedBeat(1'b1, 32'h0000_7000, 64'h70);
    tick();
    feedBeat(1'b1, 32'h0000_7000, 64'h71);
    tick();
    feedBeat(1'b1, 32'h0000_7000, 64'h72);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    tick();
    rst = 1'b0;
    feedBeat(1'b0, 32'h0, 64'h0);
    checkOutput("rst_mid_resp", {255'b0, dfp_resp}, 256'h0);
    checkOutput("rst_mid_cmds", {254'b0, bmem_read, bmem_write}, 256'h0);
    checkOutput("rst_mid_addr", {224'b0, bmem_addr}, 256'h0);
    checkOutput("rst_mid_rdata", dfp_rdata, 256'h0);
    feedBeat(1'b1, 32'h0000_7000, 64'h73);
    tick();
    feedBeat(1'b0, 32'h0, 64'h0);
    tick();
    tick();
    checkOutput("rst_mid_no_resp", 256'(respCount - respBefore), 256'd0);
    checkOutput("rst_mid_still_idle", {254'b0, bmem_read, bmem_write}, 256'h0);
`ifdef CACHELINE_ADAPTER_CHECK_EN
    checkOutput("chk_rvalid_idle_err", {255'b0, err}, 256'h1);
    rst = 1'b1;
    tick();
    rst = 1'b0;
    checkOutput("chk_err_cleared", {255'b0, err}, 256'h0);
    applyStimulus(1'b0, 1'b1, 32'h0000_8000, '0);
    tick();
    tick();
    applyStimulus(1'b0, 1'b0, 32'h0, '0);
    feedBeat(1'b1, 32'h0000_9000, 64'h80);
    tick();
    feedBeat(1'b0, 32'h0, 64'h0);
    checkOutput("chk_raddr_err", {255'b0, err}, 256'h1);
`else
    checkOutput("nochk_err_zero", {255'b0, err}, 256'h0);
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

  initial begin
    #100000;
    $display("[TB] FAIL timeout: simulation exceeded time limit");
    $fatal(1, "[TB] timeout");
  end

endmodule
